// File: rtl/cmd_master_pkg.sv
// Shared types for the cmd master bridge: response codes, FSM states and
// the data-width helper used for alignment checks.
package cmd_master_pkg;

  typedef enum logic [1:0] {
    RSP_OK       = 2'd0,
    RSP_TIMEOUT  = 2'd1,
    RSP_MISALIGN = 2'd2
  } rsp_err_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    RESP
  } state_t;

  function automatic int unsigned bytes_per_word(input int unsigned data_bits);
    return data_bits / 8;
  endfunction

endpackage

// File: rtl/intf_cmd.sv
// Single-transaction register bus between a cmd master and its slaves.
interface intf_cmd #(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned DATA_BITS = 32
);
  logic                 sel;
  logic                 rd_wr_n;
  logic [ADDR_BITS-1:0] byte_addr;
  logic [DATA_BITS-1:0] wdata;
  logic                 ack;
  logic [DATA_BITS-1:0] rdata;

  modport master (output sel, rd_wr_n, byte_addr, wdata, input ack, rdata);
  modport slave  (input sel, rd_wr_n, byte_addr, wdata, output ack, rdata);
endinterface

// File: rtl/cmd_req_fifo.sv
// Show-ahead synchronous FIFO; pointers carry an extra wrap bit so full and
// empty are distinguished without a separate counter.
module cmd_req_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 4
) (
  input  logic i_clk,
  input  logic i_arst_n,
  input  logic i_push,
  input  T     i_data,
  output logic o_full,
  input  logic i_pop,
  output T     o_data,
  output logic o_empty
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW:0] r_wr_ptr;
  logic [PW:0] r_rd_ptr;
  T            r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[PW-1:0]];

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
  end

endmodule

// File: rtl/cmd_master_bridge.sv
// Host request stream -> single cmd bus transactions -> response stream,
// with request buffering, ack timeout and misalignment rejection.
module cmd_master_bridge
  import cmd_master_pkg::*;
#(
  parameter int unsigned CMD_ADDR_BITS  = 16,
  parameter int unsigned CMD_DATA_BITS  = 32,
  parameter int unsigned REQ_FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                     i_sysclk,
  input  logic                     i_arst_n,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_rd_wr_n,
  input  logic [CMD_ADDR_BITS-1:0] i_req_addr,
  input  logic [CMD_DATA_BITS-1:0] i_req_wdata,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [CMD_DATA_BITS-1:0] o_rsp_rdata,
  output logic [1:0]               o_rsp_err,
  output logic [15:0]              o_timeout_cnt,
  intf_cmd.master                  cmd
);
  typedef struct packed {
    logic                     rd_wr_n;
    logic [CMD_ADDR_BITS-1:0] addr;
    logic [CMD_DATA_BITS-1:0] wdata;
  } cmd_req_t;

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CMD_ADDR_BITS-1:0] ALIGN_MASK =
    CMD_ADDR_BITS'(bytes_per_word(CMD_DATA_BITS) - 1);

  logic                     w_full;
  logic                     w_empty;
  logic                     w_pop;
  logic                     w_misalign;
  cmd_req_t                 w_req_in;
  cmd_req_t                 w_head;
  cmd_req_t                 r_req;
  state_t                   r_state;
  logic [TW-1:0]            r_timer;
  logic                     r_sel;
  logic                     r_rd_wr_n;
  logic [CMD_ADDR_BITS-1:0] r_byte_addr;
  logic [CMD_DATA_BITS-1:0] r_wdata;
  logic                     r_rsp_valid;
  logic [CMD_DATA_BITS-1:0] r_rsp_rdata;
  rsp_err_t                 r_rsp_err;
  logic [15:0]              r_timeout_cnt;

  assign w_req_in   = {i_req_rd_wr_n, i_req_addr, i_req_wdata};
  assign w_pop      = (r_state == IDLE) && !w_empty;
  assign w_misalign = |(w_head.addr & ALIGN_MASK);

  cmd_req_fifo #(
    .T     (cmd_req_t),
    .DEPTH (REQ_FIFO_DEPTH)
  ) u_fifo (
    .i_clk    (i_sysclk),
    .i_arst_n (i_arst_n),
    .i_push   (i_req_valid),
    .i_data   (w_req_in),
    .o_full   (w_full),
    .i_pop    (w_pop),
    .o_data   (w_head),
    .o_empty  (w_empty)
  );

  always_ff @(posedge i_sysclk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state       <= IDLE;
      r_req         <= '0;
      r_timer       <= '0;
      r_sel         <= 1'b0;
      r_rd_wr_n     <= 1'b1;
      r_byte_addr   <= '0;
      r_wdata       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= RSP_OK;
      r_timeout_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            if (w_misalign) begin
              r_rsp_err   <= RSP_MISALIGN;
              r_rsp_rdata <= '0;
              r_rsp_valid <= 1'b1;
              r_state     <= RESP;
            end else begin
              r_req   <= w_head;
              r_state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // Bus fields change only here so they stay put between transactions.
          r_sel       <= 1'b1;
          r_rd_wr_n   <= r_req.rd_wr_n;
          r_byte_addr <= r_req.addr;
          r_wdata     <= r_req.wdata;
          r_timer     <= '0;
          r_state     <= WAIT_ACK;
        end
        WAIT_ACK: begin
          r_sel <= 1'b0;
          if (cmd.ack) begin
            r_rsp_rdata <= r_rd_wr_n ? cmd.rdata : '0;
            r_rsp_err   <= RSP_OK;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= RSP_TIMEOUT;
            r_rsp_valid <= 1'b1;
            if (r_timeout_cnt != 16'hFFFF) r_timeout_cnt <= r_timeout_cnt + 1'b1;
            r_state     <= RESP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_req_ready   = !w_full;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_rsp_err     = r_rsp_err;
  assign o_timeout_cnt = r_timeout_cnt;

  assign cmd.sel       = r_sel;
  assign cmd.rd_wr_n   = r_rd_wr_n;
  assign cmd.byte_addr = r_byte_addr;
  assign cmd.wdata     = r_wdata;

endmodule

// File: tb/tb_cmd_master_bridge.sv
// Scoreboard bench: requests feed a reference model (word memory + timeout
// rule); a planned slave answers the bus; a monitor checks every response.
module tb_cmd_master_bridge;
  import cmd_master_pkg::*;

  localparam int unsigned AB = 16;
  localparam int unsigned DB = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_req_valid = 1'b0;
  logic          o_req_ready;
  logic          i_req_rd_wr_n = 1'b1;
  logic [AB-1:0] i_req_addr = '0;
  logic [DB-1:0] i_req_wdata = '0;
  logic          o_rsp_valid;
  logic          i_rsp_ready = 1'b1;
  logic [DB-1:0] o_rsp_rdata;
  logic [1:0]    o_rsp_err;
  logic [15:0]   o_timeout_cnt;
  logic          s_ack = 1'b0;
  logic          inj_ack = 1'b0;
  logic [DB-1:0] s_rdata = '0;

  always #5 clk = ~clk;

  intf_cmd #(.ADDR_BITS(AB), .DATA_BITS(DB)) cmd_if ();
  assign cmd_if.ack   = s_ack | inj_ack;
  assign cmd_if.rdata = s_rdata;

  cmd_master_bridge #(
    .CMD_ADDR_BITS  (AB),
    .CMD_DATA_BITS  (DB),
    .REQ_FIFO_DEPTH (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_sysclk      (clk),
    .i_arst_n      (rst_n),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_rd_wr_n (i_req_rd_wr_n),
    .i_req_addr    (i_req_addr),
    .i_req_wdata   (i_req_wdata),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_rsp_rdata   (o_rsp_rdata),
    .o_rsp_err     (o_rsp_err),
    .o_timeout_cnt (o_timeout_cnt),
    .cmd           (cmd_if)
  );

  // d = cycles from sel to ack; 0 = never ack
  typedef struct {
    logic          rd;
    logic [AB-1:0] addr;
    logic [DB-1:0] wdata;
    int unsigned   d;
    logic [DB-1:0] rdata;
  } plan_t;

  typedef struct {
    logic [DB-1:0] rdata;
    logic [1:0]    err;
    logic [15:0]   tcnt;
  } exp_t;

  plan_t         plan_q[$];
  exp_t          exp_q[$];
  logic [DB-1:0] model_mem [logic [AB-1:0]];
  logic [15:0]   model_tcnt = '0;
  int            total = 0;
  int            bad = 0;
  int unsigned   rdy_mode = 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: aligned requests succeed iff the slave acks within TO wait cycles.
  task automatic model_push(input logic rd, input logic [AB-1:0] addr,
                            input logic [DB-1:0] wd, input int unsigned d);
    exp_t          e;
    plan_t         p;
    logic [DB-1:0] cur;
    if ((addr % (DB / 8)) != 0) begin
      e = '{rdata: '0, err: 2'd2, tcnt: model_tcnt};
    end else begin
      cur = model_mem.exists(addr) ? model_mem[addr] : '0;
      p = '{rd: rd, addr: addr, wdata: wd, d: d, rdata: cur};
      plan_q.push_back(p);
      if (!rd && d != 0) model_mem[addr] = wd;
      if (d >= 1 && d <= TO - 1) begin
        e = '{rdata: rd ? cur : '0, err: 2'd0, tcnt: model_tcnt};
      end else begin
        if (model_tcnt != 16'hFFFF) model_tcnt++;
        e = '{rdata: '0, err: 2'd1, tcnt: model_tcnt};
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic send(input logic rd, input logic [AB-1:0] addr,
                      input logic [DB-1:0] wd, input int unsigned d);
    int unsigned n = 0;
    i_req_valid   = 1'b1;
    i_req_rd_wr_n = rd;
    i_req_addr    = addr;
    i_req_wdata   = wd;
    @(negedge clk);
    while (!o_req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("req_accept", o_req_ready, 1'b1);
    if (o_req_ready) model_push(rd, addr, wd, d);
    @(posedge clk);
    #1 i_req_valid = 1'b0;
  endtask

  task automatic lat(input string nm, input int exp_sel, input int exp_rv);
    int fs = -1;
    int fr = -1;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk);
      #1;
      if (cmd_if.sel && fs < 0) fs = k;
      if (o_rsp_valid && fr < 0) fr = k;
    end
    check({nm, "_sel_cycle"}, fs, exp_sel);
    check({nm, "_rsp_cycle"}, fr, exp_rv);
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while ((exp_q.size() != 0 || plan_q.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("drain", exp_q.size() + plan_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Planned slave: checks bus fields on sel, acks d cycles later.
  initial begin
    int unsigned cnt = 0;
    plan_t       cur;
    forever begin
      @(posedge clk);
      s_ack   <= 1'b0;
      s_rdata <= $urandom;
      if (!rst_n) cnt = 0;
      if (cnt > 1) begin
        cnt--;
      end else if (cnt == 1) begin
        cnt = 0;
        s_ack <= 1'b1;
        if (cur.rd) s_rdata <= cur.rdata;
      end
      if (rst_n && cmd_if.sel) begin
        check("sel_expected", plan_q.size() != 0, 1'b1);
        if (plan_q.size() != 0) begin
          cur = plan_q.pop_front();
          check("sel_addr", cmd_if.byte_addr, cur.addr);
          check("sel_rd_wr_n", cmd_if.rd_wr_n, cur.rd);
          if (!cur.rd) check("sel_wdata", cmd_if.wdata, cur.wdata);
          if (cur.d == 1) begin
            s_ack <= 1'b1;
            if (cur.rd) s_rdata <= cur.rdata;
          end else if (cur.d > 1) begin
            cnt = cur.d - 1;
          end
        end
      end
    end
  end

  // Response ready driver
  initial forever begin
    @(posedge clk);
    #1 i_rsp_ready = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 3) != 0);
  end

  // Response monitor / scoreboard
  initial begin
    logic          prev_sel = 1'b0;
    logic          stalled = 1'b0;
    logic [DB-1:0] h_rdata = '0;
    logic [1:0]    h_err = '0;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_sel = 1'b0;
        stalled  = 1'b0;
      end else begin
        if (cmd_if.sel) check("sel_one_cycle", prev_sel, 1'b0);
        prev_sel = cmd_if.sel;
        if (stalled) begin
          check("hold_valid", o_rsp_valid, 1'b1);
          check("hold_rdata", o_rsp_rdata, h_rdata);
          check("hold_err", o_rsp_err, h_err);
        end
        stalled = 1'b0;
        if (o_rsp_valid && i_rsp_ready) begin
          check("rsp_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rsp_rdata", o_rsp_rdata, e.rdata);
            check("rsp_err", o_rsp_err, e.err);
            check("rsp_tcnt", o_timeout_cnt, e.tcnt);
          end
        end else if (o_rsp_valid) begin
          stalled = 1'b1;
          h_rdata = o_rsp_rdata;
          h_err   = o_rsp_err;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string nm);
    check({nm, "_sel"}, cmd_if.sel, 1'b0);
    check({nm, "_rd_wr_n"}, cmd_if.rd_wr_n, 1'b1);
    check({nm, "_byte_addr"}, cmd_if.byte_addr, '0);
    check({nm, "_wdata"}, cmd_if.wdata, '0);
    check({nm, "_rsp_valid"}, o_rsp_valid, 1'b0);
    check({nm, "_rsp_rdata"}, o_rsp_rdata, '0);
    check({nm, "_rsp_err"}, o_rsp_err, 2'd0);
    check({nm, "_tcnt"}, o_timeout_cnt, 16'd0);
    check({nm, "_req_ready"}, o_req_ready, 1'b1);
  endtask

  initial begin
    logic [AB-1:0] a;
    int unsigned   d;
    #1 rst_n = 1'b0;
    #3 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency and basic write/read
    send(1'b0, 16'h0000, 32'hDEADBEEF, 1);
    lat("wr0", 2, 4);
    send(1'b1, 16'h0000, 32'h0, 1);
    lat("rd0", 2, 4);
    // Never-acking slave: timeout after TO wait cycles, then normal traffic
    send(1'b1, 16'h0008, 32'h0, 0);
    lat("timeout", 2, 2 + TO);
    send(1'b1, 16'h0000, 32'h0, 2);
    lat("after_to", 2, 5);
    // Misaligned: no bus activity
    send(1'b1, 16'h0002, 32'h0, 1);
    lat("misalign", -1, 1);
    // Ack on the last wait cycle wins; one cycle later is too late
    send(1'b1, 16'h0000, 32'h0, TO - 1);
    lat("ack_edge", 2, 2 + TO);
    send(1'b0, 16'h0004, 32'h12345678, TO);
    lat("ack_late", 2, 2 + TO);
    wait_idle();

    // Stray ack while idle
    inj_ack = 1'b1;
    @(posedge clk);
    #1 inj_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ack_tcnt", o_timeout_cnt, model_tcnt);
    check("idle_ack_no_rsp", o_rsp_valid, 1'b0);
    send(1'b1, 16'h0004, 32'h0, 3);
    wait_idle();

    // Backpressure: 5 requests with depth 4
    rdy_mode = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) send(i[0], AB'(i * 4), $urandom, 1);
    repeat (3) @(posedge clk);
    #1 check("full_ready_low", o_req_ready, 1'b0);
    repeat (15) @(posedge clk);
    rdy_mode = 1;
    wait_idle();

    // Randomized traffic
    rdy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      a = AB'($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 4) == 0) a = a | AB'($urandom_range(1, 3));
      case ($urandom_range(0, 9))
        0:       d = 0;
        1:       d = TO;
        default: d = $urandom_range(1, TO - 1);
      endcase
      send($urandom_range(0, 1) == 1, a, $urandom, d);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rdy_mode = 1;
    wait_idle();

    // Reset during WAIT_ACK
    send(1'b1, 16'h0004, 32'h0, 0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    exp_q.delete();
    plan_q.delete();
    model_tcnt = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1 check("post_reset_no_rsp", o_rsp_valid, 1'b0);
    send(1'b1, 16'h0000, 32'h0, 1);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
